amo_requester: RTL and testbench
================================

# amo_requester

Core-side initiator for the bank atomic-memory protocol. Accepts one 32-bit load, store or AMO per transaction from a core port (valid/ready), packs it into the lane, byte-enable and operand layout that the bank-side AMO unit expects, and drives the bank request/grant interface. It captures the single-cycle read data that follows a grant and holds it in a response register until the core accepts it. It sits between a core's LSU and the TCDM interconnect master port, with at most one outstanding transaction.

## Interface
- AddrWidth, 32, core byte-address width
- AddrMemWidth, 12, bank word-address width
- DataWidth, 64, bank data width; only 32 or 64 are legal (elaboration-time fatal otherwise)
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- core_req_valid_i  in  1  request valid
- core_req_ready_o  out  1  request ready
- core_addr_i  in  AddrWidth  byte address
- core_amo_i  in  4  op: 0 none, 1 swap, 2 add, 3 and, 4 or, 5 xor, 6 max, 7 maxu, 8 min, 9 minu, A cas
- core_we_i  in  1  1 store, 0 load (ignored when core_amo_i != 0)
- core_wdata_i  in  32  store data / AMO operand / CAS swap value
- core_cmp_i  in  32  CAS compare value
- core_be_i  in  4  byte enables for plain load/store
- core_rsp_valid_o  out  1  response valid
- core_rsp_ready_i  in  1  response ready
- core_rsp_data_o  out  32  load data or old memory value (AMO)
- core_rsp_err_o  out  1  request rejected, no bank access
- bank_req_o  out  1  bank request
- bank_gnt_i  in  1  bank grant
- bank_add_o  out  AddrMemWidth  word address = core_addr_i[AddrMemWidth+B-1:B], with B = log2(DataWidth/8)
- bank_amo_o  out  4  AMO op
- bank_wen_o  out  1  1 store, 0 load
- bank_wdata_o  out  DataWidth  write data
- bank_be_o  out  DataWidth/8  byte enables
- bank_rdata_i  in  DataWidth  read data, valid the cycle after a grant

## Operation
- FSM states: Idle, Req, Wait, Resp. core_req_ready_o = (state == Idle).
- Idle: on valid && ready, register the packed request. Go to Resp with err=1 and data=0 if any of:
  - AMO with addr[1:0] != 0;
  - CAS with DataWidth == 32;
  - CAS with DataWidth == 64 and addr[2] == 1.
  Otherwise go to Req.
- Req: bank_req_o=1. All bank_* outputs come from registers and are stable until bank_gnt_i. On grant, go to Wait.
- Wait: capture the selected 32-bit lane of bank_rdata_i into the response register; err=0; go to Resp.
- Resp: core_rsp_valid_o=1, data and err held stable. On core_rsp_ready_i, go to Idle.
- Packing for DataWidth 64, with upper = addr[2]:
  - Plain access: bank_wdata = {wdata, wdata}; bank_be = upper ? {be, 4'b0} : {4'b0, be}.
  - Non-CAS AMO: wdata replicated in both halves; bank_be = upper ? 8'hF0 : 8'h0F; bank_wen=0.
  - CAS: bank_wdata = {swap = core_wdata_i, cmp = core_cmp_i}; bank_be = 8'h0F.
  - Read lane = upper ? rdata[63:32] : rdata[31:0].
- Packing for DataWidth 32: bank_wdata = wdata; bank_be = be for plain access, 4'hF for AMO.
- bank_amo_o = core_amo_i registered. bank_wen = core_we_i for plain access, 0 for AMO.
- Store responses are returned too. Data is the captured rdata lane and has no meaning for stores.

## Timing
- Reset values:
  - bank_req_o=0; bank_add_o, bank_amo_o, bank_wen_o, bank_wdata_o, bank_be_o all 0.
  - core_rsp_valid_o=0, core_rsp_data_o=0, core_rsp_err_o=0.
  - state=Idle, so core_req_ready_o=1.
- Nominal latency: accept at cycle T, bank_req_o at T+1. With a grant at T+1, rdata is sampled at T+2 and core_rsp_valid_o rises at T+3.
- A grant withheld for N cycles delays the response by N cycles. Request fields never change while waiting for the grant.
- Error path: accept at T, core_rsp_valid_o=1 at T+1, bank_req_o never asserted.
- Back-to-back: the earliest next acceptance is the cycle after the response handshake. Throughput is at most one transaction per 4 cycles.
- Read data is sampled only in Wait. bank_rdata_i is ignored in all other states.
- Reset asserted mid-transaction: return to Idle immediately with reset output values. Any outstanding bank grant or rdata is dropped. No response is issued after reset.

## Test plan
- Plain 64-bit load, addr 0x0000_0104, bank grants immediately, rdata 64'hAAAA_BBBB_CCCC_DDDD -> bank_add=0x20, be=8'hF0, wen=0; rsp data 0xAAAABBBB at T+3, err=0.
- AMO add to addr 0x10, wdata 5, grant delayed 3 cycles -> bank_req held 4 cycles with stable amo=2, be=8'h0F, wdata=64'h5_0000_0005; response is the lower lane of the rdata sampled the cycle after the grant.
- CAS at addr 0x20, cmp 7, swap 9 -> bank_wdata=64'h0000_0009_0000_0007, be=8'h0F, amo=4'hA. CAS at addr 0x24 -> err=1 at T+1 with no bank_req.
- Misaligned AMO swap to addr 0x13 -> err=1, data=0, bank_req never asserted; core_req_ready_o low until the response is accepted.
- Response backpressure: core_rsp_ready_i low for 5 cycles -> rsp valid/data stable throughout, core_req_ready_o=0, no new bank_req.
- rst_ni pulsed low while in Req -> all outputs at reset values next edge. The next request completes normally with no stale response.

Source files
------------

// File: rtl/amo_requester.sv
// Core-side initiator for the bank atomic-memory protocol: packs one load/store/AMO
// into the bank lane layout, runs the request/grant handshake and holds the response.
module amo_requester #(
    parameter int AddrWidth    = 32,
    parameter int AddrMemWidth = 12,
    parameter int DataWidth    = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      core_req_valid_i,
    output logic                      core_req_ready_o,
    input  logic [AddrWidth-1:0]      core_addr_i,
    input  logic [3:0]                core_amo_i,
    input  logic                      core_we_i,
    input  logic [31:0]               core_wdata_i,
    input  logic [31:0]               core_cmp_i,
    input  logic [3:0]                core_be_i,
    output logic                      core_rsp_valid_o,
    input  logic                      core_rsp_ready_i,
    output logic [31:0]               core_rsp_data_o,
    output logic                      core_rsp_err_o,
    output logic                      bank_req_o,
    input  logic                      bank_gnt_i,
    output logic [AddrMemWidth-1:0]   bank_add_o,
    output logic [3:0]                bank_amo_o,
    output logic                      bank_wen_o,
    output logic [DataWidth-1:0]      bank_wdata_o,
    output logic [DataWidth/8-1:0]    bank_be_o,
    input  logic [DataWidth-1:0]      bank_rdata_i
);

    localparam int BeW = DataWidth / 8;
    localparam int B   = $clog2(BeW);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_accept;
    logic                    w_is_amo;
    logic                    w_is_cas;
    logic                    w_cas_bad;
    logic                    w_err;
    logic [DataWidth-1:0]    w_pack_wdata;
    logic [BeW-1:0]          w_pack_be;
    logic [31:0]             w_lane;
    logic                    w_unused;

    logic                    r_req_ready;
    logic                    r_bank_req;
    logic [AddrMemWidth-1:0] r_add;
    logic [3:0]              r_amo;
    logic                    r_wen;
    logic [DataWidth-1:0]    r_wdata;
    logic [BeW-1:0]          r_be;
    logic                    r_upper;
    logic                    r_rsp_valid;
    logic [31:0]             r_rsp_data;
    logic                    r_rsp_err;

    assign w_is_amo = (core_amo_i != 4'h0);
    assign w_is_cas = (core_amo_i == 4'hA);
    assign w_err    = (w_is_amo && (core_addr_i[1:0] != 2'b00)) || (w_is_cas && w_cas_bad);
    assign w_unused = ^core_addr_i[AddrWidth-1:AddrMemWidth+B];

    generate
        if (DataWidth == 64) begin : g_dw64
            // CAS carries {swap, cmp} in the low word slot; other accesses replicate the operand
            always_comb begin
                w_pack_wdata = {core_wdata_i, core_wdata_i};
                w_pack_be    = 8'h00;
                if (w_is_cas) begin
                    w_pack_wdata = {core_wdata_i, core_cmp_i};
                    w_pack_be    = 8'h0F;
                end else if (w_is_amo) begin
                    w_pack_be = core_addr_i[2] ? 8'hF0 : 8'h0F;
                end else begin
                    w_pack_be = core_addr_i[2] ? {core_be_i, 4'b0000} : {4'b0000, core_be_i};
                end
            end
            assign w_cas_bad = core_addr_i[2];
            assign w_lane    = r_upper ? bank_rdata_i[63:32] : bank_rdata_i[31:0];
        end else if (DataWidth == 32) begin : g_dw32
            // Single-word bank: CAS cannot carry both operands, so it is always rejected
            always_comb begin
                w_pack_wdata = core_wdata_i;
                if (w_is_amo) begin
                    w_pack_be = 4'hF;
                end else begin
                    w_pack_be = core_be_i;
                end
            end
            assign w_cas_bad = 1'b1;
            assign w_lane    = bank_rdata_i[31:0];
        end else begin : g_bad_dw
            $fatal(1, "amo_requester: DataWidth must be 32 or 64");
        end
    endgenerate

    // Next-state logic; request acceptance only happens in Idle
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (core_req_valid_i) begin
                    w_accept     = 1'b1;
                    w_state_next = w_err ? ST_RESP : ST_REQ;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bank_gnt_i) begin
                    w_state_next = ST_WAIT;
                end else begin
                    w_state_next = ST_REQ;
                end
            end
            ST_WAIT: w_state_next = ST_RESP;
            ST_RESP: begin
                if (core_rsp_ready_i) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_RESP;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, handshake flags, captured request fields and response register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_bank_req  <= 1'b0;
            r_add       <= {AddrMemWidth{1'b0}};
            r_amo       <= 4'h0;
            r_wen       <= 1'b0;
            r_wdata     <= {DataWidth{1'b0}};
            r_be        <= {BeW{1'b0}};
            r_upper     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'h0000_0000;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_req_ready <= (w_state_next == ST_IDLE);
            r_bank_req  <= (w_state_next == ST_REQ);
            r_rsp_valid <= (w_state_next == ST_RESP);
            if (w_accept) begin
                r_add   <= core_addr_i[AddrMemWidth+B-1:B];
                r_amo   <= core_amo_i;
                r_wen   <= w_is_amo ? 1'b0 : core_we_i;
                r_wdata <= w_pack_wdata;
                r_be    <= w_pack_be;
                r_upper <= core_addr_i[2];
                if (w_err) begin
                    r_rsp_data <= 32'h0000_0000;
                    r_rsp_err  <= 1'b1;
                end
            end else if (r_state == ST_WAIT) begin
                r_rsp_data <= w_lane;
                r_rsp_err  <= 1'b0;
            end
        end
    end

    assign core_req_ready_o = r_req_ready;
    assign core_rsp_valid_o = r_rsp_valid;
    assign core_rsp_data_o  = r_rsp_data;
    assign core_rsp_err_o   = r_rsp_err;
    assign bank_req_o       = r_bank_req;
    assign bank_add_o       = r_add;
    assign bank_amo_o       = r_amo;
    assign bank_wen_o       = r_wen;
    assign bank_wdata_o     = r_wdata;
    assign bank_be_o        = r_be;

endmodule

// File: tb/tb_amo_requester.sv
// Directed bench for amo_requester (DataWidth 64): expected responses are queued by the
// driver and checked by a separate monitor on each response handshake.
module tb_amo_requester;

    logic        clk_i;
    logic        rst_ni;
    logic        core_req_valid_i;
    logic        core_req_ready_o;
    logic [31:0] core_addr_i;
    logic [3:0]  core_amo_i;
    logic        core_we_i;
    logic [31:0] core_wdata_i;
    logic [31:0] core_cmp_i;
    logic [3:0]  core_be_i;
    logic        core_rsp_valid_o;
    logic        core_rsp_ready_i;
    logic [31:0] core_rsp_data_o;
    logic        core_rsp_err_o;
    logic        bank_req_o;
    logic        bank_gnt_i;
    logic [11:0] bank_add_o;
    logic [3:0]  bank_amo_o;
    logic        bank_wen_o;
    logic [63:0] bank_wdata_o;
    logic [7:0]  bank_be_o;
    logic [63:0] bank_rdata_i;

    int n_chk  = 0;
    int n_fail = 0;
    logic [32:0] exp_q[$];

    localparam logic [63:0] GARBAGE = 64'hDEAD_BEEF_5A5A_A5A5;

    amo_requester #(.AddrWidth(32), .AddrMemWidth(12), .DataWidth(64)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .core_req_valid_i (core_req_valid_i),
        .core_req_ready_o (core_req_ready_o),
        .core_addr_i      (core_addr_i),
        .core_amo_i       (core_amo_i),
        .core_we_i        (core_we_i),
        .core_wdata_i     (core_wdata_i),
        .core_cmp_i       (core_cmp_i),
        .core_be_i        (core_be_i),
        .core_rsp_valid_o (core_rsp_valid_o),
        .core_rsp_ready_i (core_rsp_ready_i),
        .core_rsp_data_o  (core_rsp_data_o),
        .core_rsp_err_o   (core_rsp_err_o),
        .bank_req_o       (bank_req_o),
        .bank_gnt_i       (bank_gnt_i),
        .bank_add_o       (bank_add_o),
        .bank_amo_o       (bank_amo_o),
        .bank_wen_o       (bank_wen_o),
        .bank_wdata_o     (bank_wdata_o),
        .bank_be_o        (bank_be_o),
        .bank_rdata_i     (bank_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Response monitor: pops one expectation per handshake
    always @(negedge clk_i) begin
        if (rst_ni && core_rsp_valid_o && core_rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rsp: got data %h err %b, no response expected",
                         core_rsp_data_o, core_rsp_err_o);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("rsp_err", {63'd0, core_rsp_err_o}, {63'd0, e[32]});
                chk("rsp_data", {32'd0, core_rsp_data_o}, {32'd0, e[31:0]});
            end
        end
    end

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_req_ready"}, {63'd0, core_req_ready_o}, 64'd1);
        chk({nm, "_bank_req"}, {63'd0, bank_req_o}, 64'd0);
        chk({nm, "_bank_add"}, {52'd0, bank_add_o}, 64'd0);
        chk({nm, "_bank_amo"}, {60'd0, bank_amo_o}, 64'd0);
        chk({nm, "_bank_wen"}, {63'd0, bank_wen_o}, 64'd0);
        chk({nm, "_bank_wdata"}, bank_wdata_o, 64'd0);
        chk({nm, "_bank_be"}, {56'd0, bank_be_o}, 64'd0);
        chk({nm, "_rsp_valid"}, {63'd0, core_rsp_valid_o}, 64'd0);
        chk({nm, "_rsp_data"}, {32'd0, core_rsp_data_o}, 64'd0);
        chk({nm, "_rsp_err"}, {63'd0, core_rsp_err_o}, 64'd0);
    endtask

    task automatic txn(input string nm,
                       input logic [31:0] addr, input logic [3:0] amo, input logic we,
                       input logic [31:0] wd, input logic [31:0] cmp, input logic [3:0] be,
                       input int gnt_dly, input logic [63:0] rdata,
                       input logic [11:0] e_add, input logic e_wen,
                       input logic [63:0] e_wdata, input logic [7:0] e_be,
                       input logic e_err, input logic [31:0] e_data, input int rsp_dly);
        exp_q.push_back({e_err, e_data});
        @(posedge clk_i); #1;
        chk({nm, "_ready_before"}, {63'd0, core_req_ready_o}, 64'd1);
        core_req_valid_i = 1'b1;
        core_addr_i      = addr;
        core_amo_i       = amo;
        core_we_i        = we;
        core_wdata_i     = wd;
        core_cmp_i       = cmp;
        core_be_i        = be;
        @(posedge clk_i); #1;
        core_req_valid_i = 1'b0;
        core_addr_i      = 32'hFFFF_FFFC;
        core_amo_i       = 4'h5;
        core_we_i        = ~we;
        core_wdata_i     = 32'h0BAD_F00D;
        core_cmp_i       = 32'h1357_9BDF;
        core_be_i        = 4'h9;
        if (e_err) begin
            chk({nm, "_err_rsp_valid"}, {63'd0, core_rsp_valid_o}, 64'd1);
            chk({nm, "_err_bank_req"}, {63'd0, bank_req_o}, 64'd0);
        end else begin
            for (int k = 0; k <= gnt_dly; k++) begin
                chk({nm, "_bank_req"}, {63'd0, bank_req_o}, 64'd1);
                chk({nm, "_bank_add"}, {52'd0, bank_add_o}, {52'd0, e_add});
                chk({nm, "_bank_amo"}, {60'd0, bank_amo_o}, {60'd0, amo});
                chk({nm, "_bank_wen"}, {63'd0, bank_wen_o}, {63'd0, e_wen});
                chk({nm, "_bank_wdata"}, bank_wdata_o, e_wdata);
                chk({nm, "_bank_be"}, {56'd0, bank_be_o}, {56'd0, e_be});
                chk({nm, "_req_ready_busy"}, {63'd0, core_req_ready_o}, 64'd0);
                bank_gnt_i = (k == gnt_dly);
                @(posedge clk_i); #1;
            end
            bank_gnt_i   = 1'b0;
            bank_rdata_i = rdata;
            chk({nm, "_wait_bank_req"}, {63'd0, bank_req_o}, 64'd0);
            chk({nm, "_wait_rsp_valid"}, {63'd0, core_rsp_valid_o}, 64'd0);
            @(posedge clk_i); #1;
            bank_rdata_i = GARBAGE;
            chk({nm, "_rsp_valid"}, {63'd0, core_rsp_valid_o}, 64'd1);
        end
        for (int k = 0; k < rsp_dly; k++) begin
            chk({nm, "_bp_valid"}, {63'd0, core_rsp_valid_o}, 64'd1);
            chk({nm, "_bp_data"}, {32'd0, core_rsp_data_o}, {32'd0, e_data});
            chk({nm, "_bp_err"}, {63'd0, core_rsp_err_o}, {63'd0, e_err});
            chk({nm, "_bp_req_ready"}, {63'd0, core_req_ready_o}, 64'd0);
            chk({nm, "_bp_bank_req"}, {63'd0, bank_req_o}, 64'd0);
            @(posedge clk_i); #1;
        end
        core_rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        core_rsp_ready_i = 1'b0;
        chk({nm, "_done_valid"}, {63'd0, core_rsp_valid_o}, 64'd0);
        chk({nm, "_done_ready"}, {63'd0, core_req_ready_o}, 64'd1);
    endtask

    initial begin
        rst_ni           = 1'b0;
        core_req_valid_i = 1'b0;
        core_addr_i      = 32'h0;
        core_amo_i       = 4'h0;
        core_we_i        = 1'b0;
        core_wdata_i     = 32'h0;
        core_cmp_i       = 32'h0;
        core_be_i        = 4'h0;
        core_rsp_ready_i = 1'b0;
        bank_gnt_i       = 1'b0;
        bank_rdata_i     = GARBAGE;
        @(posedge clk_i); @(posedge clk_i); #1;
        chk_reset_vals("reset");
        rst_ni = 1'b1;

        //   name       addr          amo   we    wdata          cmp           be    gd rdata
        //              e_add  wen   e_wdata                   e_be   err  e_data        rd
        txn("ld64_hi",  32'h0000_0104, 4'h0, 1'b0, 32'h1122_3344, 32'h0, 4'hF, 0, 64'hAAAA_BBBB_CCCC_DDDD,
            12'h020, 1'b0, 64'h1122_3344_1122_3344, 8'hF0, 1'b0, 32'hAAAA_BBBB, 0);
        txn("amo_add",  32'h0000_0010, 4'h2, 1'b1, 32'h0000_0005, 32'h0, 4'h0, 3, 64'h1234_5678_0000_002A,
            12'h002, 1'b0, 64'h0000_0005_0000_0005, 8'h0F, 1'b0, 32'h0000_002A, 0);
        txn("cas_ok",   32'h0000_0020, 4'hA, 1'b0, 32'h0000_0009, 32'h7, 4'h0, 0, 64'hFFFF_0000_0000_0007,
            12'h004, 1'b0, 64'h0000_0009_0000_0007, 8'h0F, 1'b0, 32'h0000_0007, 0);
        txn("cas_hi",   32'h0000_0024, 4'hA, 1'b0, 32'h0000_0009, 32'h7, 4'h0, 0, 64'h0,
            12'h000, 1'b0, 64'h0, 8'h00, 1'b1, 32'h0000_0000, 0);
        txn("swap_mis", 32'h0000_0013, 4'h1, 1'b0, 32'h0000_00FF, 32'h0, 4'h0, 0, 64'h0,
            12'h000, 1'b0, 64'h0, 8'h00, 1'b1, 32'h0000_0000, 2);
        txn("st_bp",    32'h0000_0208, 4'h0, 1'b1, 32'hCAFE_BABE, 32'h0, 4'h6, 0, 64'h0123_4567_89AB_CDEF,
            12'h041, 1'b1, 64'hCAFE_BABE_CAFE_BABE, 8'h06, 1'b0, 32'h89AB_CDEF, 5);
        txn("maxu_hi",  32'h0000_001C, 4'h7, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 1, 64'h0000_0011_FFFF_FFFF,
            12'h003, 1'b0, 64'h8000_0000_8000_0000, 8'hF0, 1'b0, 32'h0000_0011, 0);

        // Reset while in Req with a grant and read data pending
        @(posedge clk_i); #1;
        core_req_valid_i = 1'b1;
        core_addr_i      = 32'h0000_0040;
        core_amo_i       = 4'h0;
        core_we_i        = 1'b0;
        core_be_i        = 4'hF;
        @(posedge clk_i); #1;
        core_req_valid_i = 1'b0;
        chk("rst_mid_bank_req", {63'd0, bank_req_o}, 64'd1);
        bank_gnt_i   = 1'b1;
        bank_rdata_i = 64'h7777_7777_7777_7777;
        rst_ni       = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        @(posedge clk_i); #1;
        rst_ni     = 1'b1;
        bank_gnt_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); #1;
            chk("post_rst_valid", {63'd0, core_rsp_valid_o}, 64'd0);
            chk("post_rst_bank_req", {63'd0, bank_req_o}, 64'd0);
            chk("post_rst_ready", {63'd0, core_req_ready_o}, 64'd1);
        end
        txn("ld_after", 32'h0000_0000, 4'h0, 1'b0, 32'h0000_0000, 32'h0, 4'h3, 0, 64'h9999_0000_5566_7788,
            12'h000, 1'b0, 64'h0, 8'h03, 1'b0, 32'h5566_7788, 0);

        @(posedge clk_i); #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
